// File: rtl/sys_fifo_pkg.sv
// Shared FIFO sizing helpers and defaults for the RX (and later TX) byte buffers.
package sys_fifo_pkg;

    localparam int DEFAULT_DEPTH    = 8;
    localparam int DEFAULT_AF_LEVEL = 6;
    localparam int DROP_CNT_W       = 8;

    // Pointer width for a DEPTH-entry array; at least one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one clocked write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO between the RX synchronizer and the system controller,
// with sticky overflow status and a saturating drop counter.
module rx_byte_fifo
    import sys_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AF_LEVEL   = DEFAULT_AF_LEVEL
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     WR_DATA,
    input  logic                      WR_EN,
    output logic [DATA_WIDTH-1:0]     RD_DATA,
    output logic                      RD_VALID,
    input  logic                      RD_READY,
    output logic                      FULL,
    output logic                      ALMOST_FULL,
    output logic [ptr_width(DEPTH):0] COUNT,
    output logic                      OVERFLOW,
    input  logic                      OVF_CLR,
    output logic [DROP_CNT_W-1:0]     DROP_CNT
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic                  pop;
    logic                  push;
    logic                  drop;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign pop  = (count != '0) && RD_READY;
    assign push = WR_EN && ((count != DEPTH_C) || pop);
    assign drop = WR_EN && (count == DEPTH_C) && !pop;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (WR_DATA),
        .raddr (rd_ptr),
        .rdata (RD_DATA)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (OVF_CLR) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign COUNT       = count;
    assign RD_VALID    = (count != '0);
    assign FULL        = (count == DEPTH_C);
    assign ALMOST_FULL = (count >= AF_C);
    assign OVERFLOW    = overflow;
    assign DROP_CNT    = drop_cnt;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Randomized and directed scoreboard bench for rx_byte_fifo against a queue-based reference.
module tb_rx_byte_fifo;

    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       rd_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       almost_full;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    int         m_drops = 0;

    rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .CLK         (clk),
        .RST         (rst),
        .WR_DATA     (wr_data),
        .WR_EN       (wr_en),
        .RD_DATA     (rd_data),
        .RD_VALID    (rd_valid),
        .RD_READY    (rd_ready),
        .FULL        (full),
        .ALMOST_FULL (almost_full),
        .COUNT       (count),
        .OVERFLOW    (overflow),
        .OVF_CLR     (ovf_clr),
        .DROP_CNT    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: status against the reference, and each handshaken byte against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
            check("full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
            if (rd_valid && rd_ready && exp_q.size() > 0) begin
                check("rd_data", 32'(rd_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    // Reference push/drop rules, evaluated after any pop of this cycle has left the queue.
    always @(posedge clk) begin
        if (rst) begin
            if (wr_en) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(wr_data);
                end else if (!ovf_clr) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (ovf_clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    end

    task automatic cyc(input logic we, input logic [7:0] d, input logic rr, input logic clr);
        wr_en    = we;
        wr_data  = d;
        rd_ready = rr;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic fill_seq(input int n);
        for (int i = 1; i <= n; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        #1;
        exp_q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_cnt), 32'd0);
        wr_en = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        hard_reset();

        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("first_data", 32'(rd_data), 32'hA5);
        check("first_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_empty", 32'(rd_valid), 32'd0);
        idle(2);

        fill_seq(5);
        check("af_before", 32'(almost_full), 32'd0);
        cyc(1'b1, 8'd6, 1'b0, 1'b0);
        check("af_at_6", 32'(almost_full), 32'd1);
        cyc(1'b1, 8'd7, 1'b0, 1'b0);
        cyc(1'b1, 8'd8, 1'b0, 1'b0);
        check("full_at_8", 32'(full), 32'd1);
        drain(9);
        check("drained", 32'(count), 32'd0);

        fill_seq(8);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0);
        check("drops3", 32'(drop_cnt), 32'd3);
        check("ovf_set", 32'(overflow), 32'd1);
        check("head_kept", 32'(rd_data), 32'h01);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("full_pushpop_count", 32'(count), 32'd8);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h66, 1'b0, 1'b1);
        check("clr_beats_drop", 32'(drop_cnt), 32'd0);
        drain(9);

        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        for (int i = 3; i < 23; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        check("stream_count", 32'(count), 32'd3);
        drain(4);

        fill_seq(5);
        hard_reset();
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        check("post_reset_head", 32'(rd_data), 32'h3C);
        drain(2);

        fill_seq(8);
        for (int i = 0; i < 260; i++) cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        check("drop_saturate", 32'(drop_cnt), 32'd255);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 40) == 0));
        end
        drain(10);
        check("final_empty", 32'(rd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
